register_diff: RTL and testbench



---
 rtl/register_diff_pkg.sv | 23 ++
 rtl/register_diff.sv | 64 ++++++
 tb/tb_register_diff.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/register_diff_pkg.sv
// Shared defaults and types for the register_diff serial-in/parallel-out shifter.
package register_diff_pkg;

  localparam int unsigned WIDTH_DEFAULT      = 4;
  localparam int unsigned SHIFT_LEFT_DEFAULT = 1;
  localparam int unsigned WIDTH_MIN          = 2;
  localparam int unsigned WIDTH_MAX          = 32;

  typedef logic [WIDTH_DEFAULT-1:0] word_t;

  // Index of the bit that receives d_in on each shift.
  function automatic int unsigned entry_idx(input int unsigned width,
                                            input int unsigned shift_left);
    return (shift_left != 0) ? 0 : width - 1;
  endfunction

  // Index of the bit that leaves the register on the next shift.
  function automatic int unsigned exit_idx(input int unsigned width,
                                           input int unsigned shift_left);
    return (shift_left != 0) ? width - 1 : 0;
  endfunction

endpackage

// File: rtl/register_diff.sv
// WIDTH-bit serial-in/parallel-out shift register with a serial exit tap.
// Optional registered edge flag on output diff when REGISTER_DIFF_EDGE_EN is defined.
module register_diff
  import register_diff_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEFAULT,
  parameter int unsigned SHIFT_LEFT = SHIFT_LEFT_DEFAULT
) (
  output logic [WIDTH-1:0] out,
  input  logic             d_in,
  input  logic             clk,
  output logic             d_out,
  input  logic             reset
`ifdef REGISTER_DIFF_EDGE_EN
  ,
  output logic             diff
`endif
);

  localparam int unsigned ENTRY = entry_idx(WIDTH, SHIFT_LEFT);
  localparam int unsigned EXIT  = exit_idx(WIDTH, SHIFT_LEFT);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("register_diff: WIDTH out of range 2..32");
  end

  logic [WIDTH-1:0] shift_p0;
  logic [WIDTH-1:0] shift_next;

  // Shift direction is fixed at elaboration; only one path exists in hardware.
  if (SHIFT_LEFT != 0) begin : g_left
    assign shift_next = {shift_p0[WIDTH-2:0], d_in};
  end else begin : g_right
    assign shift_next = {d_in, shift_p0[WIDTH-1:1]};
  end

  // Stage p0: the stored word; reset wins over shifting.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_p0 <= '0;
    end else begin
      shift_p0 <= shift_next;
    end
  end

  assign out   = shift_p0;
  assign d_out = shift_p0[EXIT];

`ifdef REGISTER_DIFF_EDGE_EN
  logic diff_p0;

  // Stage p0: flag set when the incoming bit differs from the current entry bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      diff_p0 <= 1'b0;
    end else begin
      diff_p0 <= d_in ^ shift_p0[ENTRY];
    end
  end

  assign diff = diff_p0;
`endif

endmodule

// File: tb/tb_register_diff.sv
// Bench for register_diff: directed vector tables plus randomized run against a history model.
module tb_register_diff;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic d_in = 1'b0;

  logic [3:0] out_l, out_r;
  logic [6:0] out_w;
  logic       dout_l, dout_r, dout_w;
`ifdef REGISTER_DIFF_EDGE_EN
  logic       diff_l, diff_r, diff_w;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  register_diff #(.WIDTH(4), .SHIFT_LEFT(1)) u_l (
    .out(out_l), .d_in(d_in), .clk(clk), .d_out(dout_l), .reset(reset)
`ifdef REGISTER_DIFF_EDGE_EN
    , .diff(diff_l)
`endif
  );

  register_diff #(.WIDTH(4), .SHIFT_LEFT(0)) u_r (
    .out(out_r), .d_in(d_in), .clk(clk), .d_out(dout_r), .reset(reset)
`ifdef REGISTER_DIFF_EDGE_EN
    , .diff(diff_r)
`endif
  );

  register_diff #(.WIDTH(7), .SHIFT_LEFT(0)) u_w (
    .out(out_w), .d_in(d_in), .clk(clk), .d_out(dout_w), .reset(reset)
`ifdef REGISTER_DIFF_EDGE_EN
    , .diff(diff_w)
`endif
  );

  typedef struct {
    logic       rst;
    logic       din;
    logic [3:0] exp_out;
    logic       exp_dout;
    logic       exp_diff;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic r, input logic d);
    @(negedge clk);
    reset = r;
    d_in  = d;
    @(posedge clk);
    #1;
  endtask

  // Model: list of bits entered since the last reset, newest first.
  bit hist[$];

  function automatic logic [31:0] model_out(input int w, input int left);
    logic [31:0] v = '0;
    for (int k = 0; k < w; k++) begin
      if (k < hist.size()) v[(left != 0) ? k : (w - 1 - k)] = hist[k];
    end
    return v;
  endfunction

  function automatic logic model_dout(input int w);
    return (w - 1 < hist.size()) ? hist[w-1] : 1'b0;
  endfunction

  vec_t tab_l[$];
  vec_t tab_r[$];

  initial begin
    logic exp_diff;
    logic prev;

    // reset, shift-in, flush, mid-stream reset, held reset
    tab_l = '{
      '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0},
      '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0},
      '{1'b0, 1'b1, 4'b0001, 1'b0, 1'b1},
      '{1'b0, 1'b0, 4'b0010, 1'b0, 1'b1},
      '{1'b0, 1'b1, 4'b0101, 1'b0, 1'b1},
      '{1'b0, 1'b1, 4'b1011, 1'b1, 1'b0},
      '{1'b0, 1'b0, 4'b0110, 1'b0, 1'b1},
      '{1'b0, 1'b0, 4'b1100, 1'b1, 1'b0},
      '{1'b0, 1'b0, 4'b1000, 1'b1, 1'b0},
      '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0},
      '{1'b0, 1'b0, 4'b0000, 1'b0, 1'b0},
      '{1'b0, 1'b1, 4'b0001, 1'b0, 1'b1},
      '{1'b0, 1'b0, 4'b0010, 1'b0, 1'b1},
      '{1'b0, 1'b1, 4'b0101, 1'b0, 1'b1},
      '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0},
      '{1'b0, 1'b1, 4'b0001, 1'b0, 1'b1},
      '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0},
      '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0},
      '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0},
      '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0},
      '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0}
    };

    tab_r = '{
      '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0},
      '{1'b0, 1'b1, 4'b1000, 1'b0, 1'b1},
      '{1'b0, 1'b1, 4'b1100, 1'b0, 1'b0},
      '{1'b0, 1'b0, 4'b0110, 1'b0, 1'b1},
      '{1'b0, 1'b1, 4'b1011, 1'b1, 1'b1},
      '{1'b0, 1'b0, 4'b0101, 1'b1, 1'b1}
    };

    foreach (tab_l[i]) begin
      apply(tab_l[i].rst, tab_l[i].din);
      chk($sformatf("left_out[%0d]", i), 32'(out_l), 32'(tab_l[i].exp_out));
      chk($sformatf("left_dout[%0d]", i), 32'(dout_l), 32'(tab_l[i].exp_dout));
`ifdef REGISTER_DIFF_EDGE_EN
      chk($sformatf("left_diff[%0d]", i), 32'(diff_l), 32'(tab_l[i].exp_diff));
`endif
    end

    foreach (tab_r[i]) begin
      apply(tab_r[i].rst, tab_r[i].din);
      chk($sformatf("right_out[%0d]", i), 32'(out_r), 32'(tab_r[i].exp_out));
      chk($sformatf("right_dout[%0d]", i), 32'(dout_r), 32'(tab_r[i].exp_dout));
`ifdef REGISTER_DIFF_EDGE_EN
      chk($sformatf("right_diff[%0d]", i), 32'(diff_r), 32'(tab_r[i].exp_diff));
`endif
    end

    // Multi-cycle corner: a lone 1 must reach the exit tap after exactly WIDTH edges.
    apply(1'b1, 1'b0);
    apply(1'b0, 1'b1);
    for (int k = 2; k <= 4; k++) begin
      apply(1'b0, 1'b0);
      chk($sformatf("latency_dout_k%0d", k), 32'(dout_l), (k == 4) ? 32'd1 : 32'd0);
    end
    apply(1'b0, 1'b0);
    chk("latency_gone", 32'(out_l), 32'd0);

    // Randomized run against the history model, with occasional resets.
    apply(1'b1, 1'b1);
    hist.delete();
    for (int n = 0; n < 400; n++) begin
      logic r, d;
      r = ($urandom_range(0, 19) == 0);
      d = 1'($urandom);
      prev = (hist.size() > 0) ? hist[0] : 1'b0;
      exp_diff = r ? 1'b0 : (d ^ prev);
      if (r) hist.delete();
      else begin
        hist.push_front(d);
        if (hist.size() > 32) void'(hist.pop_back());
      end
      apply(r, d);
      chk("rand_out_l", 32'(out_l), model_out(4, 1));
      chk("rand_out_r", 32'(out_r), model_out(4, 0));
      chk("rand_out_w", 32'(out_w), model_out(7, 0));
      chk("rand_dout_l", 32'(dout_l), 32'(model_dout(4)));
      chk("rand_dout_r", 32'(dout_r), 32'(model_dout(4)));
      chk("rand_dout_w", 32'(dout_w), 32'(model_dout(7)));
`ifdef REGISTER_DIFF_EDGE_EN
      chk("rand_diff_l", 32'(diff_l), 32'(exp_diff));
      chk("rand_diff_r", 32'(diff_r), 32'(exp_diff));
      chk("rand_diff_w", 32'(diff_w), 32'(exp_diff));
`else
      if (exp_diff === 1'bx) chk("rand_diff_known", 32'(exp_diff), 32'd0);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
